// File: rtl/qdiv_pkg.sv
// qdiv_pkg: shared FSM encoding and quotient-width helper for the Q-format divider
package qdiv_pkg;
  typedef enum logic [1:0] {
    QDIV_IDLE = 2'd0,
    QDIV_CALC = 2'd1,
    QDIV_DONE = 2'd2
  } qdiv_state_e;
  function automatic int quo_width(input int n, input int q);
    return n - 1 + q;
  endfunction
endpackage

// File: rtl/qdiv_step.sv
// qdiv_step: one restoring compare-subtract step producing {qbit, next_rem}
module qdiv_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic         next_bit,
  input  logic [N-2:0] divisor,
  output logic         qbit,
  output logic [N-1:0] next_rem
);
  logic [N-1:0] shifted;
  assign shifted = {rem[N-2:0], next_bit};
  // a set rem MSB means the true shifted value exceeds any divisor
  assign qbit = rem[N-1] | (shifted >= {1'b0, divisor});
  assign next_rem = qbit ? shifted - {1'b0, divisor} : shifted;
endmodule

// File: rtl/qdiv.sv
// qdiv: sequential sign-magnitude (N,Q) fixed-point divider, one quotient bit per cycle
module qdiv
  import qdiv_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_result,
  output logic         o_busy,
  output logic         o_complete,
  output logic         o_ovr,
  output logic         o_div0
);
  localparam int W  = quo_width(N, Q);
  localparam int CW = $clog2(W + 1);
  qdiv_state_e   state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  dvd, quo, quo_next;
  logic [N-1:0]  rem, next_rem;
  logic [N-2:0]  dsr;
  logic          sgn, qbit, sat;
  qdiv_step #(.N(N)) u_step (
    .rem      (rem),
    .next_bit (dvd[W-1]),
    .divisor  (dsr),
    .qbit     (qbit),
    .next_rem (next_rem)
  );
  assign quo_next = {quo[W-2:0], qbit};
  // any quotient bit above the N-1 bit magnitude field forces saturation
  assign sat = |quo_next[W-1:N-1];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= QDIV_IDLE;
      cnt        <= '0;
      dvd        <= '0;
      quo        <= '0;
      rem        <= '0;
      dsr        <= '0;
      sgn        <= 1'b0;
      o_result   <= '0;
      o_busy     <= 1'b0;
      o_complete <= 1'b0;
      o_ovr      <= 1'b0;
      o_div0     <= 1'b0;
    end else begin
      case (state)
        QDIV_IDLE: begin
          o_complete <= 1'b0;
          if (i_start) begin
            sgn    <= i_dividend[N-1] ^ i_divisor[N-1];
            o_busy <= 1'b1;
            o_ovr  <= 1'b0;
            o_div0 <= 1'b0;
            if (i_divisor[N-2:0] == '0) begin
              state      <= QDIV_DONE;
              o_result   <= {i_dividend[N-1] ^ i_divisor[N-1], {(N-1){1'b1}}};
              o_ovr      <= 1'b1;
              o_div0     <= 1'b1;
              o_complete <= 1'b1;
            end else begin
              state <= QDIV_CALC;
              dvd   <= {i_dividend[N-2:0], {Q{1'b0}}};
              dsr   <= i_divisor[N-2:0];
              rem   <= '0;
              quo   <= '0;
              cnt   <= '0;
            end
          end
        end
        QDIV_CALC: begin
          rem <= next_rem;
          quo <= quo_next;
          dvd <= {dvd[W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state      <= QDIV_DONE;
            o_result   <= {sgn, sat ? {(N-1){1'b1}} : quo_next[N-2:0]};
            o_ovr      <= sat;
            o_complete <= 1'b1;
          end
        end
        QDIV_DONE: begin
          state      <= QDIV_IDLE;
          o_complete <= 1'b0;
          o_busy     <= 1'b0;
        end
        default: state <= QDIV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qdiv.sv
// tb_qdiv: randomized scoreboard bench for qdiv against an integer-division reference model
module tb_qdiv;
  localparam int N = 32;
  localparam int Q = 15;
  localparam int W = N - 1 + Q;
  typedef struct {
    logic [N-1:0] res;
    logic         ovr;
    logic         div0;
    int           cyc;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0, divisor = '0;
  logic [N-1:0] result;
  logic         busy, complete, ovr, div0;
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  exp_t         sb[$];
  qdiv #(.N(N), .Q(Q)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_result   (result),
    .o_busy     (busy),
    .o_complete (complete),
    .o_ovr      (ovr),
    .o_div0     (div0)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(input logic [N-1:0] dd, input logic [N-1:0] ds, input int c);
    exp_t e;
    longint unsigned num, quo;
    logic [N-2:0] mag;
    e.div0 = (ds[N-2:0] == 0);
    if (e.div0) begin
      e.ovr = 1'b1;
      mag = '1;
    end else begin
      num = longint'(dd[N-2:0]) << Q;
      quo = num / longint'(ds[N-2:0]);
      e.ovr = quo > ((64'd1 << (N-1)) - 1);
      mag = e.ovr ? '1 : quo[N-2:0];
    end
    e.res = {dd[N-1] ^ ds[N-1], mag};
    e.cyc = c + 1 + (e.div0 ? 0 : W);
    return e;
  endfunction
  task automatic monitor();
    exp_t e;
    logic prev_c;
    prev_c = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_c = 1'b0;
      else begin
        if (prev_c) begin
          vectors++;
          if (busy || complete) begin
            miscompares++;
            $display("FAIL after_done: busy=%b complete=%b, required 0 0", busy, complete);
          end
        end
        if (complete) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_complete: result=%h at cycle %0d, none expected", result, cyc);
          end else begin
            e = sb.pop_front();
            if (result !== e.res || ovr !== e.ovr || div0 !== e.div0 || cyc != e.cyc) begin
              miscompares++;
              $display("FAIL result: got %h ovr=%b div0=%b cyc=%0d, required %h ovr=%b div0=%b cyc=%0d",
                       result, ovr, div0, cyc, e.res, e.ovr, e.div0, e.cyc);
            end
          end
        end
        prev_c = complete;
      end
    end
  endtask
  task automatic check_zero(input string name);
    vectors++;
    if (result !== '0 || busy !== 1'b0 || complete !== 1'b0 || ovr !== 1'b0 || div0 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: result=%h busy=%b complete=%b ovr=%b div0=%b, required all zero",
               name, result, busy, complete, ovr, div0);
    end
  endtask
  task automatic issue(input logic [N-1:0] dd, input logic [N-1:0] ds, input bit noise);
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, t);
    end
    sb.push_back(model(dd, ds, cyc));
    start = 1'b1;
    dividend = dd;
    divisor = ds;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    if (noise) begin
      for (int i = 0; i < 4; i++) begin
        if (busy) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    logic [N-1:0] dd, ds;
    logic [N-1:0] dir_dd[7] = '{32'h00018000, 32'h80030000, 32'h00008000, 32'h00010000,
                                32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    logic [N-1:0] dir_ds[7] = '{32'h00010000, 32'h00010000, 32'h00018000, 32'h80000000,
                                32'h00004000, 32'h00010000, 32'h80000001};
    fork
      monitor();
    join_none
    #1;
    check_zero("reset_state");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("after_release");
    for (int i = 0; i < 7; i++) issue(dir_dd[i], dir_ds[i], 1'b0);
    drain();
    issue(32'h00018000, 32'h00010000, 1'b1);
    issue(32'h00010000, 32'h00000000, 1'b1);
    drain();
    issue(32'h80030000, 32'h00010000, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero("reset_mid_calc");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 5) @(negedge clk);
    check_zero("no_complete_after_abort");
    issue(32'h00018000, 32'h00010000, 1'b0);
    drain();
    for (int i = 0; i < 150; i++) begin
      dd = $urandom;
      ds = $urandom;
      ds[N-2:0] = ds[N-2:0] >> $urandom_range(0, N - 2);
      if ($urandom_range(0, 19) == 0) ds[N-2:0] = '0;
      issue(dd, ds, $urandom_range(0, 3) == 0);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
